// File: rtl/fifo_push_arbiter_pkg.sv
// fifo_push_arbiter_pkg: shared state type and defaults for the FIFO push arbiter
package fifo_push_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BURST, STALL} ty_FifoPushArbStates;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int BURST_MAX_DEF = 8;
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// fifo_rr_pick: finds the first active request at or after the round-robin pointer
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2
) (
  input  logic [NUM_REQ-1:0] reqIn,
  input  logic [OWNER_W-1:0] rrPtr,
  output logic [OWNER_W-1:0] winner,
  output logic               anyReq
);
  logic [OWNER_W-1:0] idx;
  // walk the ring farthest-first so the request nearest rrPtr is written last
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = OWNER_W'((int'(rrPtr) + k) % NUM_REQ);
      if (reqIn[idx]) winner = idx;
    end
  end
  assign anyReq = |reqIn;
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin, burst-bounded sharing of one FIFO push port
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  localparam int OWNER_W = owner_w(NUM_REQ),
  localparam int CNT_W = $clog2(BURST_MAX + 1)
) (
  input  logic                      ck,
  input  logic                      arstN,
  input  logic                      arbEna,
  input  logic [NUM_REQ-1:0]        reqIn,
  input  logic [NUM_REQ*DATA_W-1:0] dataIn,
  output logic [NUM_REQ-1:0]        gntOut,
  output logic                      fifoPush,
  output logic [DATA_W-1:0]         fifoData,
  input  logic                      fifoFull,
  output ty_FifoPushArbStates       status,
  output logic [OWNER_W-1:0]        owner
);
  ty_FifoPushArbStates state, state_n;
  logic [OWNER_W-1:0] rr_ptr, winner, owner_n, owner_inc;
  logic [CNT_W-1:0] beat_cnt, cnt_n;
  logic [DATA_W-1:0] din [NUM_REQ];
  logic any_req, own_req, last, fin;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_din
    assign din[g] = dataIn[g*DATA_W +: DATA_W];
  end

  fifo_rr_pick #(.NUM_REQ(NUM_REQ), .OWNER_W(OWNER_W)) u_pick (
    .reqIn(reqIn),
    .rrPtr(rr_ptr),
    .winner(winner),
    .anyReq(any_req)
  );

  assign own_req = reqIn[owner];
  assign last = beat_cnt == CNT_W'(BURST_MAX - 1);
  assign owner_inc = (owner == OWNER_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign fifoPush = (state == BURST) && own_req && !fifoFull;
  assign gntOut = NUM_REQ'(fifoPush) << owner;
  assign fifoData = fifoPush ? din[owner] : '0;
  assign status = state;

  // next state; an owner drop outranks full, and a lowered arbEna ends the burst after the current beat
  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n = beat_cnt;
    fin = 1'b0;
    case (state)
      IDLE: if (arbEna && any_req) begin
        state_n = BURST;
        owner_n = winner;
        cnt_n = '0;
      end
      BURST: if (!own_req) fin = 1'b1;
        else if (fifoFull) state_n = STALL;
        else begin
          cnt_n = beat_cnt + 1'b1;
          fin = last || !arbEna;
        end
      STALL: if (!own_req) fin = 1'b1;
        else if (!fifoFull) state_n = BURST;
      default: state_n = IDLE;
    endcase
    if (fin) state_n = IDLE;
  end

  // state, owner, round-robin pointer and beat counter
  always_ff @(posedge ck or negedge arstN) begin
    if (!arstN) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      beat_cnt <= cnt_n;
      rr_ptr <= fin ? owner_inc : rr_ptr;
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scoreboard bench for the FIFO push arbiter
module tb_fifo_push_arbiter;
  import fifo_push_arbiter_pkg::*;

  typedef struct {int idx; int cyc;} exp_t;

  logic ck = 1'b0;
  logic arstN = 1'b0;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  exp_t q[3][$];

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  function automatic logic [31:0] dval(input int u, input int r);
    return {8'(8'hD0 + u), 8'(r), 16'h5A5A};
  endfunction

  logic a_ena, a_full, a_push, b_ena, b_full, b_push, c_ena, c_full, c_push;
  logic [3:0] a_req, a_gnt, b_req, b_gnt;
  logic [2:0] c_req, c_gnt;
  logic [127:0] a_din, b_din;
  logic [95:0] c_din;
  logic [31:0] a_dout, b_dout, c_dout;
  logic [1:0] a_own, b_own, c_own;
  ty_FifoPushArbStates a_st, b_st, c_st;

  assign a_din = {dval(0, 3), dval(0, 2), dval(0, 1), dval(0, 0)};
  assign b_din = {dval(1, 3), dval(1, 2), dval(1, 1), dval(1, 0)};
  assign c_din = {dval(2, 2), dval(2, 1), dval(2, 0)};

  fifo_push_arbiter #(.NUM_REQ(4), .DATA_W(32), .BURST_MAX(8)) dut_a (
    .ck(ck), .arstN(arstN), .arbEna(a_ena), .reqIn(a_req), .dataIn(a_din), .gntOut(a_gnt),
    .fifoPush(a_push), .fifoData(a_dout), .fifoFull(a_full), .status(a_st), .owner(a_own)
  );
  fifo_push_arbiter #(.NUM_REQ(4), .DATA_W(32), .BURST_MAX(2)) dut_b (
    .ck(ck), .arstN(arstN), .arbEna(b_ena), .reqIn(b_req), .dataIn(b_din), .gntOut(b_gnt),
    .fifoPush(b_push), .fifoData(b_dout), .fifoFull(b_full), .status(b_st), .owner(b_own)
  );
  fifo_push_arbiter #(.NUM_REQ(3), .DATA_W(32), .BURST_MAX(2)) dut_c (
    .ck(ck), .arstN(arstN), .arbEna(c_ena), .reqIn(c_req), .dataIn(c_din), .gntOut(c_gnt),
    .fifoPush(c_push), .fifoData(c_dout), .fifoFull(c_full), .status(c_st), .owner(c_own)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic want(input int u, input int idx, input int c);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    q[u].push_back(e);
  endtask

  task automatic mon(input int u, input logic push, input logic [3:0] gnt, input logic [31:0] data,
                     input logic full, input logic [1:0] own);
    exp_t e;
    if (push) begin
      chk($sformatf("u%0d push while full", u), 64'(full), 64'(0));
      if (q[u].size() == 0) chk($sformatf("u%0d unexpected push", u), 64'(gnt), 64'(0));
      else begin
        e = q[u].pop_front();
        chk($sformatf("u%0d grant", u), 64'(gnt), 64'(4'b1 << e.idx));
        chk($sformatf("u%0d data", u), 64'(data), 64'(dval(u, e.idx)));
        chk($sformatf("u%0d owner", u), 64'(own), 64'(e.idx));
        chk($sformatf("u%0d push cycle", u), 64'(cyc), 64'(e.cyc));
      end
    end else chk($sformatf("u%0d idle outputs", u), {28'(0), gnt, data}, 64'(0));
  endtask

  always @(negedge ck) begin
    mon(0, a_push, a_gnt, a_dout, a_full, a_own);
    mon(1, b_push, b_gnt, b_dout, b_full, b_own);
    mon(2, c_push, {1'b0, c_gnt}, c_dout, c_full, c_own);
  end

  task automatic step(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  initial begin
    int t0;
    a_ena = 1'b1; b_ena = 1'b1; c_ena = 1'b1;
    a_full = 1'b0; b_full = 1'b0; c_full = 1'b0;
    a_req = '0; b_req = '0; c_req = '0;
    step(2);
    chk("reset status a", 64'(a_st), 64'(IDLE));
    chk("reset status c", 64'(c_st), 64'(IDLE));
    chk("reset owner b", 64'(b_own), 64'(0));
    arstN = 1'b1;
    step(1);
    // reset in the middle of an r1 burst
    a_req = 4'b0010; t0 = cyc;
    want(0, 1, t0 + 1); want(0, 1, t0 + 2);
    step(3);
    chk("t1 mid burst", 64'(a_st), 64'(BURST));
    chk("t1 mid burst owner", 64'(a_own), 64'(1));
    arstN = 1'b0;
    #1;
    chk("t1 async status", 64'(a_st), 64'(IDLE));
    chk("t1 async push", 64'(a_push), 64'(0));
    chk("t1 async gnt", 64'(a_gnt), 64'(0));
    chk("t1 async owner", 64'(a_own), 64'(0));
    a_req = '0;
    step(2);
    arstN = 1'b1;
    step(1);
    chk("t1 owner after release", 64'(a_own), 64'(0));
    // owner drop with r3 and r0 pending, full in the drop cycle
    a_req = 4'b1010; t0 = cyc;
    for (int i = 1; i <= 3; i++) want(0, 1, t0 + i);
    for (int i = 6; i <= 13; i++) want(0, 3, t0 + i);
    step(4);
    a_req = 4'b1001; a_full = 1'b1;
    step(1);
    a_full = 1'b0;
    chk("t4 drop to idle", 64'(a_st), 64'(IDLE));
    step(1);
    chk("t4 r3 wins", 64'(a_own), 64'(3));
    step(8);
    a_req = '0;
    step(2);
    // full stall after the first beat of an r2 burst
    a_req = 4'b0100; t0 = cyc;
    want(0, 2, t0 + 1);
    for (int i = 8; i <= 14; i++) want(0, 2, t0 + i);
    step(2);
    a_full = 1'b1;
    step(1);
    chk("t3 stall status", 64'(a_st), 64'(STALL));
    chk("t3 stall owner", 64'(a_own), 64'(2));
    step(4);
    a_full = 1'b0;
    step(1);
    chk("t3 resume status", 64'(a_st), 64'(BURST));
    step(7);
    chk("t3 end status", 64'(a_st), 64'(IDLE));
    a_req = '0;
    step(2);
    // arbEna dropped mid-burst
    a_req = 4'b0001; t0 = cyc;
    for (int i = 1; i <= 3; i++) want(0, 0, t0 + i);
    for (int i = 9; i <= 16; i++) want(0, 0, t0 + i);
    step(3);
    a_ena = 1'b0;
    step(3);
    chk("t6 idle while disabled", 64'(a_st), 64'(IDLE));
    step(2);
    a_ena = 1'b1;
    step(9);
    chk("t6 end status", 64'(a_st), 64'(IDLE));
    a_req = '0;
    // rotation with all four requesting, two-beat bursts
    b_req = 4'b1111; t0 = cyc;
    for (int j = 0; j < 5; j++) begin
      want(1, j % 4, t0 + 1 + 3 * j);
      want(1, j % 4, t0 + 2 + 3 * j);
    end
    step(15);
    chk("t2 end status", 64'(b_st), 64'(IDLE));
    b_req = '0;
    step(2);
    // three requesters: r2 with full on its last beat, then wrap to r0
    c_req = 3'b100; t0 = cyc;
    want(2, 2, t0 + 1); want(2, 2, t0 + 4); want(2, 0, t0 + 6); want(2, 0, t0 + 7);
    step(2);
    c_full = 1'b1;
    step(1);
    c_full = 1'b0;
    chk("t5 stall status", 64'(c_st), 64'(STALL));
    chk("t5 stall owner", 64'(c_own), 64'(2));
    step(2);
    c_req = 3'b011;
    step(1);
    chk("t5 wrap owner", 64'(c_own), 64'(0));
    step(2);
    c_req = '0;
    step(3);
    for (int u = 0; u < 3; u++) chk($sformatf("u%0d beats outstanding", u), 64'(q[u].size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
